// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) round helpers for the encrypt and decrypt datapaths.
// Bytes are packed FIPS-order: byte i sits at [127-8i -: 8], row i%4, column i/4.
package aes_pkg;

    localparam int unsigned AES256_NR = 14;
    localparam int unsigned RK_IDX_W  = 4;

    typedef logic [127:0]        aes_state_t;
    typedef logic [RK_IDX_W-1:0] rk_idx_t;

    localparam rk_idx_t RK_LAST = rk_idx_t'(AES256_NR);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRound,
        StFinal,
        StDone
    } aes_fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Row r rotates right by r columns.
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                               gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                               gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                               gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                               gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic aes_state_t add_round_key(input aes_state_t s, input aes_state_t k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes256_inv_cipher_if.sv
// Block handshake and round-key store port bundle of the AES-256 inverse cipher.
interface aes256_inv_cipher_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_data;
    rk_idx_t    rk_idx;
    aes_state_t rk_data;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_data;

    modport master (
        output in_valid, in_data, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data
    );

endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine map followed by GF(2^8) inversion (x^254).
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    logic [7:0] a;
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;

    assign a = {data_i[6:0], data_i[7]} ^ {data_i[4:0], data_i[7:5]} ^
               {data_i[1:0], data_i[7:2]} ^ 8'h05;

    // Addition chain to a^254; maps 0 to 0 as the S-box requires.
    assign x2   = gf_mul(a, a);
    assign x3   = gf_mul(x2, a);
    assign x6   = gf_mul(x3, x3);
    assign x12  = gf_mul(x6, x6);
    assign x15  = gf_mul(x12, x3);
    assign x30  = gf_mul(x15, x15);
    assign x60  = gf_mul(x30, x30);
    assign x120 = gf_mul(x60, x60);
    assign x240 = gf_mul(x120, x120);
    assign x252 = gf_mul(x240, x12);
    assign data_o = gf_mul(x252, x2);

endmodule

// File: rtl/aes256_inv_cipher.sv
// Iterative AES-256 inverse cipher, one round per clock, round keys read from an external
// store with one cycle of read latency.
module aes256_inv_cipher
    import aes_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    aes256_inv_cipher_if.slave        bus
);

    aes_fsm_e   state_q, state_d;
    rk_idx_t    round_q, round_d;
    rk_idx_t    rk_idx_q, rk_idx_d;
    aes_state_t data_q, data_d;
    aes_state_t out_q, out_d;

    aes_state_t shifted;
    aes_state_t subbed;
    aes_state_t keyed;

    assign shifted = inv_shift_rows(data_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .data_i (shifted[127-8*i -: 8]),
            .data_o (subbed[127-8*i -: 8])
        );
    end

    assign keyed = add_round_key(subbed, bus.rk_data);

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        rk_idx_d = rk_idx_q;
        data_d   = data_q;
        out_d    = out_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    data_d   = bus.in_data;
                    rk_idx_d = RK_LAST - 4'd1;
                    state_d  = StInit;
                end
            end
            StInit: begin
                data_d   = add_round_key(data_q, bus.rk_data);
                round_d  = RK_LAST - 4'd1;
                rk_idx_d = (rk_idx_q == '0) ? '0 : rk_idx_q - 4'd1;
                state_d  = StRound;
            end
            StRound: begin
                data_d   = inv_mix_columns(keyed);
                round_d  = round_q - 4'd1;
                rk_idx_d = (rk_idx_q == '0) ? '0 : rk_idx_q - 4'd1;
                if (round_q == 4'd1) state_d = StFinal;
            end
            StFinal: begin
                data_d   = keyed;
                out_d    = keyed;
                rk_idx_d = RK_LAST;
                state_d  = StDone;
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            round_q  <= '0;
            rk_idx_q <= RK_LAST;
            data_q   <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            rk_idx_q <= rk_idx_d;
            data_q   <= data_d;
            out_q    <= out_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.rk_idx    = rk_idx_q;
    assign bus.out_data  = out_q;

endmodule

// File: tb/tb_aes256_inv_cipher.sv
// Directed bench for aes256_inv_cipher: FIPS-197 C.3 known answer, timing, backpressure,
// back-to-back blocks, busy-input rejection and asynchronous reset mid-block.
module tb_aes256_inv_cipher;

    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   cyc;
    int   acc_cnt;

    logic [127:0] exp_q[$];
    logic [127:0] rk_mem [0:15];

    aes256_inv_cipher_if bus ();

    aes256_inv_cipher dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Round-key store with one cycle of read latency.
    always @(posedge clk) bus.rk_data <= rk_mem[bus.rk_idx];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.in_valid && bus.in_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard: every completed output handshake consumes one expected block.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            check("out_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
        end
    end

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
               {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    task automatic expand_key();
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = KEY[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0};
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++) rk_mem[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        rk_mem[15] = '0;
    endtask

    // Offers one block and returns just after the accepting edge with in_valid dropped.
    task automatic send(input logic [127:0] ct, input logic [127:0] exp);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = ct;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus.in_ready;
        end
        check("send_ready", 128'(seen), 128'(1));
        if (seen) exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        int          acc0;
        int          acc_t[2];
        int          n_acc;
        logic [3:0]  rk_exp;

        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        acc_cnt  = 0;
        expand_key();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_rk_idx", 128'(bus.rk_idx), 128'(14));
        check("rst_out_data", bus.out_data, '0);
        rst_n = 1'b1;

        // C.3 vector: cycle-accurate rk_idx and out_valid from the accept edge
        send(CT, PT);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            rk_exp = (k <= 14) ? 4'(14 - k) : ((k == 15) ? 4'd0 : 4'd14);
            check($sformatf("c3_rk_idx_T%0d", k), 128'(bus.rk_idx), 128'(rk_exp));
            check($sformatf("c3_out_valid_T%0d", k), 128'(bus.out_valid), 128'(k == 16));
            if (k == 1) check("c3_busy_in_ready", 128'(bus.in_ready), 128'(0));
        end
        check("c3_out_data", bus.out_data, PT);
        wait_drain("c3_drain");

        // Backpressure
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(CT, PT);
        for (int i = 0; i < 40 && !bus.out_valid; i++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(bus.out_valid), 128'(1));
            check("bp_out_data", bus.out_data, PT);
            check("bp_in_ready", 128'(bus.in_ready), 128'(0));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_after", 128'(bus.in_ready), 128'(1));
        wait_drain("bp_drain");

        // Back-to-back with in_valid held high
        n_acc = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = CT;
        for (int i = 0; i < 60 && n_acc < 2; i++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                acc_t[n_acc] = cyc;
                n_acc++;
                exp_q.push_back(PT);
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("b2b_accepts", 128'(n_acc), 128'(2));
        check("b2b_interval", 128'(acc_t[1] - acc_t[0]), 128'(17));
        wait_drain("b2b_drain");

        // Input changes ignored while busy
        acc0 = acc_cnt;
        send(CT, PT);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.in_valid = ~i[0];
            bus.in_data  = '1;
            @(negedge clk);
            check("busy_in_ready", 128'(bus.in_ready), 128'(0));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_drain("busy_drain");
        check("busy_accepts", 128'(acc_cnt - acc0), 128'(1));

        // Asynchronous reset mid-block
        send(CT, PT);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("mid_rst_out_data", bus.out_data, '0);
        check("mid_rst_rk_idx", 128'(bus.rk_idx), 128'(14));
        check("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(CT, PT);
        wait_drain("post_rst_drain");
        check("post_rst_out_data", bus.out_data, PT);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
